// File: rtl/rv32i_types.sv
// Shared core types: superscalar width and the retirement RAT FSM states.
package rv32i_types;

    localparam int WAY = 2;

    typedef enum logic {
        RRAT_IDLE,
        RRAT_RESTORE
    } rrat_state_t;

endpackage

// File: rtl/rrat_commit_unit_if.sv
// Commit and restore bus of the retirement RAT.
// master: ROB / front-end RAT side.  slave: rrat_commit_unit.
interface rrat_commit_unit_if #(
    parameter int WAY               = rv32i_types::WAY,
    parameter int ARCH_WIDTH        = 5,
    parameter int PRF_WIDTH         = 6,
    parameter int RESTORE_PER_CYCLE = 8,
    parameter int OFF_WIDTH         = $clog2(WAY + 1)
);
    // commit side
    logic [WAY-1:0]        en;
    logic [ARCH_WIDTH-1:0] rd_arch      [WAY];
    logic [PRF_WIDTH-1:0]  new_phy_reg  [WAY];
    logic [WAY-1:0]        freed_valid;
    logic [PRF_WIDTH-1:0]  freed_phy    [WAY];
    logic [OFF_WIDTH-1:0]  freed_offset [WAY];
    logic [OFF_WIDTH-1:0]  freed_count;

    // restore side
    logic                  flush_req;
    logic                  restore_valid;
    logic                  restore_ready;
    logic [ARCH_WIDTH-1:0] restore_base;
    logic [PRF_WIDTH-1:0]  restore_phy  [RESTORE_PER_CYCLE];
    logic                  restore_done;

    modport master (
        output en, rd_arch, new_phy_reg, flush_req, restore_ready,
        input  freed_valid, freed_phy, freed_offset, freed_count,
        input  restore_valid, restore_base, restore_phy, restore_done
    );

    modport slave (
        input  en, rd_arch, new_phy_reg, flush_req, restore_ready,
        output freed_valid, freed_phy, freed_offset, freed_count,
        output restore_valid, restore_base, restore_phy, restore_done
    );

endinterface

// File: rtl/rrat_bundle_resolve.sv
// Same-bundle old-mapping resolution and free-list release reporting.
// A younger way writing the same arch register as an older way frees the
// older way's new physical register, not the committed map entry.
module rrat_bundle_resolve #(
    parameter int WAY        = rv32i_types::WAY,
    parameter int ARCH_WIDTH = 5,
    parameter int PRF_WIDTH  = 6,
    localparam int OFF_WIDTH = $clog2(WAY + 1)
) (
    input  logic [WAY-1:0]        en,
    input  logic [ARCH_WIDTH-1:0] rd_arch      [WAY],
    input  logic [PRF_WIDTH-1:0]  new_phy_reg  [WAY],
    input  logic [PRF_WIDTH-1:0]  map_phy      [WAY],
    output logic [WAY-1:0]        freed_valid,
    output logic [PRF_WIDTH-1:0]  freed_phy    [WAY],
    output logic [OFF_WIDTH-1:0]  freed_offset [WAY],
    output logic [OFF_WIDTH-1:0]  freed_count
);

    logic [PRF_WIDTH-1:0] old_phy [WAY];
    logic [OFF_WIDTH-1:0] run_cnt;

    // Resolve old mapping per way, then form freed flags and prefix offsets.
    always_comb begin
        run_cnt = '0;
        for (int i = 0; i < WAY; i++) begin
            old_phy[i] = map_phy[i];
            for (int j = 0; j < WAY; j++) begin
                if (j < i && en[j] && rd_arch[j] == rd_arch[i]) begin
                    old_phy[i] = new_phy_reg[j];
                end
            end
            freed_offset[i] = run_cnt;
            freed_valid[i]  = en[i] && (rd_arch[i] != '0) && (old_phy[i] != '0);
            freed_phy[i]    = freed_valid[i] ? old_phy[i] : '0;
            run_cnt         = run_cnt + OFF_WIDTH'(freed_valid[i]);
        end
        freed_count = run_cnt;
    end

endmodule

// File: rtl/rrat_commit_unit.sv
// Retirement RAT: applies up to WAY commits per cycle to the committed
// arch->phys map, reports released physical registers, and streams the map
// back to the front-end RAT on flush.
// Optional feature macro: RRAT_COMMIT_CNT_EN (retired instruction counter).
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   RRAT_IDLE    | accepting commits, waiting for flush_req
//   RRAT_RESTORE | streaming map beats, commits blocked, busy=1
module rrat_commit_unit #(
    parameter int WAY               = rv32i_types::WAY,
    parameter int ARCH_ENTRY        = 32,
    parameter int PRF_ENTRY         = 64,
    parameter int RESTORE_PER_CYCLE = 8,
    localparam int ARCH_WIDTH       = $clog2(ARCH_ENTRY),
    localparam int PRF_WIDTH        = $clog2(PRF_ENTRY)
) (
    input  logic                 clk,
    input  logic                 rst,
    rrat_commit_unit_if.slave    bus,
    output logic                 busy,
    output logic [PRF_WIDTH-1:0] rrat [ARCH_ENTRY],
    output logic [63:0]          commit_total
);
    import rv32i_types::*;

    localparam int NBEAT  = ARCH_ENTRY / RESTORE_PER_CYCLE;
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    rrat_state_t          state, state_next;
    logic [BEAT_W-1:0]    beat, beat_next;
    logic                 done_q, done_next;
    logic [PRF_WIDTH-1:0] map_q   [ARCH_ENTRY];
    logic [PRF_WIDTH-1:0] map_phy [WAY];
    logic [WAY-1:0]       commit_en;
    logic                 last_beat;

    // Commits are only honoured outside a restore.
    assign commit_en = bus.en & {WAY{state == RRAT_IDLE}};
    assign busy      = (state == RRAT_RESTORE);
    assign last_beat = (beat == BEAT_W'(NBEAT - 1));

    // Committed-map lookup for each way's destination.
    always_comb begin
        for (int w = 0; w < WAY; w++) begin
            map_phy[w] = map_q[bus.rd_arch[w]];
        end
    end

    rrat_bundle_resolve #(
        .WAY        (WAY),
        .ARCH_WIDTH (ARCH_WIDTH),
        .PRF_WIDTH  (PRF_WIDTH)
    ) u_resolve (
        .en           (commit_en),
        .rd_arch      (bus.rd_arch),
        .new_phy_reg  (bus.new_phy_reg),
        .map_phy      (map_phy),
        .freed_valid  (bus.freed_valid),
        .freed_phy    (bus.freed_phy),
        .freed_offset (bus.freed_offset),
        .freed_count  (bus.freed_count)
    );

    // Map update; later ways overwrite earlier ones so the youngest wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_ENTRY; i++) begin
                map_q[i] <= PRF_WIDTH'(i);
            end
        end else begin
            for (int w = 0; w < WAY; w++) begin
                if (commit_en[w] && bus.rd_arch[w] != '0) begin
                    map_q[bus.rd_arch[w]] <= bus.new_phy_reg[w];
                end
            end
        end
    end

    // Restore FSM state, beat index and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RRAT_IDLE;
            beat   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            beat   <= beat_next;
            done_q <= done_next;
        end
    end

    // Restore FSM next-state and handshake; a flush mid-restore rewinds to beat 0.
    always_comb begin
        state_next        = state;
        beat_next         = beat;
        done_next         = 1'b0;
        bus.restore_valid = 1'b0;
        unique case (state)
            RRAT_IDLE: begin
                if (bus.flush_req) begin
                    state_next = RRAT_RESTORE;
                    beat_next  = '0;
                end
            end
            RRAT_RESTORE: begin
                bus.restore_valid = 1'b1;
                if (bus.flush_req) begin
                    beat_next = '0;
                end else if (bus.restore_ready) begin
                    if (last_beat) begin
                        state_next = RRAT_IDLE;
                        beat_next  = '0;
                        done_next  = 1'b1;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end
            default: begin
                state_next = RRAT_IDLE;
                beat_next  = '0;
            end
        endcase
    end

    // Beat payload: the map slice starting at beat*RESTORE_PER_CYCLE.
    always_comb begin
        bus.restore_base = ARCH_WIDTH'(int'(beat) * RESTORE_PER_CYCLE);
        for (int k = 0; k < RESTORE_PER_CYCLE; k++) begin
            bus.restore_phy[k] = map_q[ARCH_WIDTH'(int'(beat) * RESTORE_PER_CYCLE + k)];
        end
    end

    assign bus.restore_done = done_q;

    // Expose the committed map.
    always_comb begin
        for (int i = 0; i < ARCH_ENTRY; i++) begin
            rrat[i] = map_q[i];
        end
    end

`ifdef RRAT_COMMIT_CNT_EN
    logic [63:0] cnt_q;
    logic [64:0] cnt_sum;

    assign cnt_sum = {1'b0, cnt_q} + 65'($countones(bus.en));

    // Retired-instruction counter, saturating, frozen during restore.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state == RRAT_IDLE) begin
            cnt_q <= cnt_sum[64] ? '1 : cnt_sum[63:0];
        end
    end

    assign commit_total = cnt_q;
`else
    assign commit_total = '0;
`endif

`ifndef SYNTHESIS
    // The ROB must not commit while the map is being streamed out.
    a_no_commit_in_restore: assert property (
        @(posedge clk) disable iff (rst) busy |-> (bus.en == '0)
    );
`endif

endmodule

// File: tb/tb_rrat_commit_unit.sv
// Self-checking bench for rrat_commit_unit: sequential map model plus
// directed commit and restore scenarios.
module tb_rrat_commit_unit;

    localparam int WAY = 2;
    localparam int AE  = 32;
    localparam int PE  = 64;
    localparam int RPC = 8;
    localparam int AW  = 5;
    localparam int PW  = 6;
    localparam int NB  = AE / RPC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rrat_commit_unit_if #(.WAY(WAY), .ARCH_WIDTH(AW), .PRF_WIDTH(PW),
                          .RESTORE_PER_CYCLE(RPC)) bus ();

    logic          busy;
    logic [PW-1:0] rrat [AE];
    logic [63:0]   commit_total;

    rrat_commit_unit #(.WAY(WAY), .ARCH_ENTRY(AE), .PRF_ENTRY(PE),
                       .RESTORE_PER_CYCLE(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .rrat         (rrat),
        .commit_total (commit_total)
    );

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_map [AE];
    bit              m_busy;
    int              m_beat;
    bit              m_done;
    bit              m_done_nxt;
    longint unsigned m_cnt;

    logic [WAY-1:0] e_fv;
    int             e_fp   [WAY];
    int             e_off  [WAY];
    int             e_cnt;
    int             e_work [AE];

    // Apply the bundle one way at a time to a scratch copy of the map:
    // each way's old mapping is whatever the scratch map holds when it commits.
    function automatic void model_resolve();
        int a, o;
        e_work = m_map;
        e_cnt  = 0;
        for (int w = 0; w < WAY; w++) begin
            e_fv[w]  = 1'b0;
            e_fp[w]  = 0;
            e_off[w] = e_cnt;
            a = int'(bus.rd_arch[w]);
            if (bus.en[w] && a != 0 && !m_busy) begin
                o = e_work[a];
                e_work[a] = int'(bus.new_phy_reg[w]);
                if (o != 0) begin
                    e_fv[w] = 1'b1;
                    e_fp[w] = o;
                    e_cnt++;
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AE; i++) m_map[i] = i;
            m_busy = 0;
            m_beat = 0;
            m_done = 0;
            m_cnt  = 0;
        end else begin
            m_done_nxt = 0;
            if (!m_busy) begin
                model_resolve();
                m_map = e_work;
                if (m_cnt + longint'($countones(bus.en)) < m_cnt) m_cnt = '1;
                else m_cnt = m_cnt + longint'($countones(bus.en));
                if (bus.flush_req) begin
                    m_busy = 1;
                    m_beat = 0;
                end
            end else if (bus.flush_req) begin
                m_beat = 0;
            end else if (bus.restore_ready) begin
                if (m_beat == NB - 1) begin
                    m_busy     = 0;
                    m_beat     = 0;
                    m_done_nxt = 1;
                end else begin
                    m_beat++;
                end
            end
            m_done = m_done_nxt;
        end
        started = 1;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            model_resolve();
            chk("freed_valid", 64'(bus.freed_valid), 64'(e_fv));
            for (int w = 0; w < WAY; w++) begin
                chk("freed_phy", 64'(bus.freed_phy[w]), 64'(e_fp[w]));
                chk("freed_offset", 64'(bus.freed_offset[w]), 64'(e_off[w]));
            end
            chk("freed_count", 64'(bus.freed_count), 64'(e_cnt));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("restore_valid", 64'(bus.restore_valid), 64'(m_busy));
            chk("restore_done", 64'(bus.restore_done), 64'(m_done));
            if (m_busy) begin
                chk("restore_base", 64'(bus.restore_base), 64'(m_beat * RPC));
                for (int k = 0; k < RPC; k++)
                    chk("restore_phy", 64'(bus.restore_phy[k]), 64'(m_map[m_beat * RPC + k]));
            end
            for (int i = 0; i < AE; i++)
                chk("rrat", 64'(rrat[i]), 64'(m_map[i]));
`ifdef RRAT_COMMIT_CNT_EN
            chk("commit_total", commit_total, m_cnt);
`else
            chk("commit_total", commit_total, 64'd0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        bus.en = '0;
        for (int w = 0; w < WAY; w++) begin
            bus.rd_arch[w]     = '0;
            bus.new_phy_reg[w] = '0;
        end
    endtask

    task automatic commit2(input logic [1:0] e, input int a0, input int p0,
                           input int a1, input int p1);
        bus.en             = e;
        bus.rd_arch[0]     = AW'(a0);
        bus.new_phy_reg[0] = PW'(p0);
        bus.rd_arch[1]     = AW'(a1);
        bus.new_phy_reg[1] = PW'(p1);
    endtask

    int seen_bases [$];
    int probe_b0_phy5;
    int probe_b0_phy4;
    int probe_b1_phy1;

    // Runs a restore already kicked off; n counts cycles after the flush cycle.
    task automatic run_restore(input int stall_from, input int stall_n,
                               input int restart_at, output int lat);
        lat = -1;
        seen_bases.delete();
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            bus.flush_req     = (n == restart_at);
            bus.restore_ready = !(n >= stall_from && n < stall_from + stall_n);
            if (bus.restore_valid && bus.restore_base == 0) begin
                probe_b0_phy5 = int'(bus.restore_phy[5]);
                probe_b0_phy4 = int'(bus.restore_phy[4]);
            end
            if (bus.restore_valid && bus.restore_base == 8)
                probe_b1_phy1 = int'(bus.restore_phy[1]);
            if (bus.restore_valid && bus.restore_ready && !bus.flush_req)
                seen_bases.push_back(int'(bus.restore_base));
            if (bus.restore_done) begin
                lat = n;
                break;
            end
        end
        bus.flush_req     = 1'b0;
        bus.restore_ready = 1'b1;
        if (lat < 0) chk("restore_timeout", 64'd0, 64'd1);
    endtask

    int lat;

    initial begin
        rst               = 1'b1;
        bus.flush_req     = 1'b0;
        bus.restore_ready = 1'b1;
        clear_commit();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(bus.restore_valid), 64'd0);
        chk("rst_rrat5", 64'(rrat[5]), 64'd5);
        chk("rst_total", commit_total, 64'd0);

        // single commit
        step();
        commit2(2'b01, 5, 40, 0, 0);
        @(negedge clk);
        chk("t1_fv", 64'(bus.freed_valid), 64'd1);
        chk("t1_fp0", 64'(bus.freed_phy[0]), 64'd5);
        chk("t1_cnt", 64'(bus.freed_count), 64'd1);
        step();
        clear_commit();
        @(negedge clk);
        chk("t1_rrat5", 64'(rrat[5]), 64'd40);

        // same-arch bypass inside one bundle
        step();
        commit2(2'b11, 7, 41, 7, 42);
        @(negedge clk);
        chk("t2_fp0", 64'(bus.freed_phy[0]), 64'd7);
        chk("t2_fp1", 64'(bus.freed_phy[1]), 64'd41);
        chk("t2_off1", 64'(bus.freed_offset[1]), 64'd1);
        chk("t2_cnt", 64'(bus.freed_count), 64'd2);
        step();
        clear_commit();
        @(negedge clk);
        chk("t2_rrat7", 64'(rrat[7]), 64'd42);

        // x0 write dropped
        step();
        commit2(2'b11, 0, 43, 3, 44);
        @(negedge clk);
        chk("t3_fv", 64'(bus.freed_valid), 64'd2);
        chk("t3_off1", 64'(bus.freed_offset[1]), 64'd0);
        chk("t3_cnt", 64'(bus.freed_count), 64'd1);
        chk("t3_fp0", 64'(bus.freed_phy[0]), 64'd0);
        step();
        clear_commit();
        @(negedge clk);
        chk("t3_rrat0", 64'(rrat[0]), 64'd0);
        chk("t3_rrat3", 64'(rrat[3]), 64'd44);

        // two distinct arch regs
        step();
        commit2(2'b11, 1, 50, 2, 51);
        @(negedge clk);
        chk("t4_fp0", 64'(bus.freed_phy[0]), 64'd1);
        chk("t4_fp1", 64'(bus.freed_phy[1]), 64'd2);
        chk("t4_off1", 64'(bus.freed_offset[1]), 64'd1);
        step();

        // mapping to phys 0 is never freed
        commit2(2'b01, 4, 0, 0, 0);
        step();
        commit2(2'b11, 4, 45, 4, 46);
        @(negedge clk);
        chk("t5_fv", 64'(bus.freed_valid), 64'd2);
        chk("t5_fp1", 64'(bus.freed_phy[1]), 64'd45);
        chk("t5_off1", 64'(bus.freed_offset[1]), 64'd0);
        step();

        // flush with a commit in the same cycle, ready tied high
        commit2(2'b01, 9, 60, 0, 0);
        bus.flush_req = 1'b1;
        step();
        clear_commit();
        bus.flush_req = 1'b0;
        run_restore(0, 0, 0, lat);
        chk("t6_latency", 64'(lat), 64'd5);
        chk("t6_nbeats", 64'(seen_bases.size()), 64'd4);
        for (int b = 0; b < seen_bases.size() && b < NB; b++)
            chk("t6_base", 64'(seen_bases[b]), 64'(b * 8));
        chk("t6_b0_phy5", 64'(probe_b0_phy5), 64'd40);
        chk("t6_b0_phy4", 64'(probe_b0_phy4), 64'd46);
        chk("t6_b1_phy1", 64'(probe_b1_phy1), 64'd60);
        @(negedge clk);
        chk("t6_busy_after", 64'(busy), 64'd0);
`ifdef RRAT_COMMIT_CNT_EN
        chk("t6_total", commit_total, 64'd11);
`else
        chk("t6_total", commit_total, 64'd0);
`endif

        // stall three cycles on beat 1
        step();
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        run_restore(2, 3, 0, lat);
        chk("t7_latency", 64'(lat), 64'd8);
        chk("t7_nbeats", 64'(seen_bases.size()), 64'd4);

        // flush during restore rewinds to beat 0
        step();
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        run_restore(0, 0, 2, lat);
        chk("t8_latency", 64'(lat), 64'd7);
        chk("t8_nbeats", 64'(seen_bases.size()), 64'd5);

        // reset during beat 2
        step();
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        begin
            bit hit;
            hit = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (bus.restore_valid && bus.restore_base == 16) begin
                    hit = 1;
                    break;
                end
            end
            chk("t9_reach_beat2", 64'(hit), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t9_busy", 64'(busy), 64'd0);
        chk("t9_valid", 64'(bus.restore_valid), 64'd0);
        chk("t9_rrat7", 64'(rrat[7]), 64'd7);
        chk("t9_rrat9", 64'(rrat[9]), 64'd9);
        chk("t9_total", commit_total, 64'd0);
        step();
        rst = 1'b0;

        // commit after reset
        commit2(2'b11, 6, 33, 8, 34);
        @(negedge clk);
        chk("t10_fp0", 64'(bus.freed_phy[0]), 64'd6);
        chk("t10_fp1", 64'(bus.freed_phy[1]), 64'd8);
        step();
        clear_commit();
        step();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rrat_commit_unit.md
# rrat_commit_unit

Parametrised retirement RAT for the out-of-order core. It takes up to WAY committing instructions per cycle from the ROB and updates the architectural-to-physical map. It reports which previous physical registers are released to the free list, using per-way prefix offsets. On a flush it streams the committed map back to the front-end RAT over a ready/valid handshake, RESTORE_PER_CYCLE entries per beat.

## Interface
- WAY, 2: commit width; also the superscalar width in rv32i_types.
- ARCH_ENTRY, 32: architectural registers; arch 0 is x0.
- PRF_ENTRY, 64: physical registers; phys 0 is reserved for x0.
- RESTORE_PER_CYCLE, 8: map entries per restore beat; must divide ARCH_ENTRY.
- ARCH_WIDTH / PRF_WIDTH, $clog2 of the above: derived, do not override.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- en  in  WAY  commit valid per way; way 0 is oldest.
- rd_arch[WAY]  in  ARCH_WIDTH  destination architectural register.
- new_phy_reg[WAY]  in  PRF_WIDTH  physical register being committed.
- freed_valid  out  WAY  old mapping of this way is released.
- freed_phy[WAY]  out  PRF_WIDTH  released physical register; 0 when not valid.
- freed_offset[WAY]  out  $clog2(WAY+1)  count of freed_valid bits in lower ways.
- freed_count  out  $clog2(WAY+1)  total freed_valid this cycle.
- flush_req  in  1  one-cycle pulse from the ROB that starts a restore.
- restore_valid  out  1  restore beat valid.
- restore_ready  in  1  front-end RAT accepts the beat.
- restore_base  out  ARCH_WIDTH  first arch index of the beat.
- restore_phy[RESTORE_PER_CYCLE]  out  PRF_WIDTH  map entries restore_base+k.
- restore_done  out  1  one-cycle pulse after the last beat is accepted.
- busy  out  1  high while in RESTORE.
- rrat  out  ARCH_ENTRY x PRF_WIDTH  current committed map.
- commit_total  out  64  retired instruction counter; see Configuration.

## Operation
- Reset:
  - map[i] = i (identity).
  - State IDLE; beat index 0.
  - restore_valid, restore_done, busy = 0; commit_total = 0.
- Old-mapping resolution, combinational, for way i with en[i]=1 and rd_arch[i]!=0:
  - old[i] = new_phy_reg[j], where j is the highest j<i with en[j]=1 and rd_arch[j]==rd_arch[i].
  - Otherwise old[i] = map[rd_arch[i]].
- Freeing: freed_valid[i] = en[i] && rd_arch[i]!=0 && old[i]!=0.
- freed_offset is the exclusive prefix sum of freed_valid; freed_count is the total sum.
- Map update at posedge:
  - For every enabled way with rd_arch!=0, map[rd_arch] <= new_phy_reg.
  - When several ways hit the same arch, the highest way wins.
  - Writes to x0 are dropped and never free anything.
- States:
  - IDLE: flush_req goes to RESTORE with beat index 0. Commits in the flush_req cycle are applied first, so the restore streams the post-commit map.
  - RESTORE:
    - restore_valid = 1; restore_base = beat*RESTORE_PER_CYCLE; restore_phy[k] = map[restore_base+k].
    - On restore_valid && restore_ready the beat index increments.
    - On the last beat (ARCH_ENTRY/RESTORE_PER_CYCLE - 1) accepted, go to IDLE and pulse restore_done the next cycle.
  - Without restore_ready the beat holds with stable outputs.
- en must be 0 while busy; commits are ignored in RESTORE, and a simulation assertion fires.
- flush_req while in RESTORE restarts the restore at beat 0. The map is unchanged, so this only restarts the stream.
- rst at any point aborts a restore immediately and restores the reset values.

## Timing
- freed_* outputs are valid in the same cycle as en (zero latency).
- The rrat output reflects commits one cycle later.
- Restore with restore_ready tied high: first beat in the cycle after flush_req; ARCH_ENTRY/RESTORE_PER_CYCLE beats back to back; restore_done one cycle after the last beat. For the defaults that is 4 beats, with restore_done at cycle 5 after flush_req.
- busy rises the cycle after flush_req and falls in the same cycle restore_done pulses.

## Configuration
- RRAT_COMMIT_CNT_EN defined: commit_total increments every cycle by popcount(en), counting x0 commits and excluding cycles while busy. It saturates at all-ones.
- RRAT_COMMIT_CNT_EN undefined: commit_total is tied to 0 and no counter flops exist.

## Structure
- rv32i_types (package) holds:
  - WAY.
  - rrat_state_t enum {RRAT_IDLE, RRAT_RESTORE}.
- Sub-module rrat_bundle_resolve (combinational): same-bundle bypass, old[i], freed_valid, freed_offset and freed_count. Parametrised on WAY, ARCH_WIDTH and PRF_WIDTH.
- The top level holds the map flops, the restore FSM, the beat counter and the optional counter.

## Test plan
- After reset, commit way0 {arch 5, phy 40} → freed_valid=01, freed_phy[0]=5, freed_count=1; next cycle rrat[5]=40.
- Same bundle, way0 {arch 7, phy 41} and way1 {arch 7, phy 42} → freed_phy[0]=7, freed_phy[1]=41, freed_offset[1]=1; next cycle rrat[7]=42.
- way0 {arch 0, phy 43} and way1 {arch 3, phy 44} → freed_valid=10, freed_offset[1]=0, freed_count=1; rrat[0] stays 0.
- flush_req with restore_ready=1 → 4 beats with bases 0, 8, 16, 24 holding the map contents; restore_done at cycle 5; busy high for cycles 1-4.
- Restore with restore_ready low for 3 cycles on beat 1 → restore_base stays 8 with stable data; total latency grows by 3.
- rst asserted during beat 2 → next cycle busy=0, restore_valid=0, rrat[i]=i. With RRAT_COMMIT_CNT_EN, commit_total=0.
